apb_master_bridge: RTL
======================

# apb_master_bridge

Converts a simple valid/ready command stream into APB transfers (SETUP then ACCESS phases) and returns one response per command. It sits directly upstream of the APB slave and drives the slave's psel/penable/pwrite/paddr/pwdata bus. It also consumes prdata/pready/pslverr and protects the fabric from a hung slave with a wait-state timeout.

## Interface
- ADDR_W, 32, width of req_addr/paddr
- DATA_W, 32, width of write/read data
- TIMEOUT, 16, max ACCESS cycles with pready=0 before abort; 0 disables the timeout
- Clocking and reset are fixed: one clock; reset is asynchronous and active-high. The ports are named clk and rst.
- clk  input  1  sole clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  command present
- req_ready  output  1  bridge can accept a command
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  transfer address
- req_wdata  input  DATA_W  write data (ignored for reads)
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer takes response
- rsp_rdata  output  DATA_W  read data; 0 for writes, errors and timeouts
- rsp_err  output  1  pslverr seen, or timeout
- rsp_timeout  output  1  transfer aborted by timeout
- psel, penable, pwrite  output  1 each  APB control
- paddr  output  ADDR_W  APB address
- pwdata  output  DATA_W  APB write data
- prdata  input  DATA_W  APB read data
- pready, pslverr  input  1 each  APB completion and error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- Reset values:
  - All outputs are 0 and the state is IDLE.
  - req_ready is 0 while rst is high.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, register req_write/addr/wdata into pwrite/paddr/pwdata and go to SETUP.
- SETUP: psel=1, penable=0. Always advances to ACCESS after one cycle.
- ACCESS: psel=1, penable=1.
  - On a rising edge with pready=1, the transfer completes:
    - rsp_rdata = prdata for reads, 0 for writes.
    - rsp_err = pslverr and rsp_timeout = 0.
    - Go to RESP.
  - pslverr and prdata are sampled only in an ACCESS cycle with pready=1. They are ignored otherwise.
  - Wait counter:
    - Cleared on entry to ACCESS.
    - Increments on each ACCESS edge with pready=0.
    - When the counter reaches TIMEOUT (TIMEOUT>0), abort: rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
    - Counter width is $clog2(TIMEOUT+1), minimum 1 bit. It never wraps.
- RESP: psel=0, penable=0, rsp_valid=1.
  - Response fields stay stable until rsp_valid&&rsp_ready, then go to IDLE.
  - rsp_valid drops on the cycle after the handshake edge.
- paddr/pwrite/pwdata are stable from SETUP through the last ACCESS cycle. They hold their last value afterwards.
- req_ready=0 in SETUP, ACCESS and RESP. Exactly one outstanding transfer at a time.
- All APB and response outputs are registered; req_ready is decoded from the state register.
- Reset mid-transfer forces IDLE immediately:
  - psel/penable and rsp_valid fall asynchronously.
  - The in-flight command is dropped with no response.

## Timing
- With zero wait states, for a command accepted at edge N:
  - SETUP during cycle N..N+1
  - ACCESS during N+1..N+2, with pready sampled at edge N+2
  - rsp_valid high after edge N+2
- Command-to-response latency is 3 cycles plus the number of wait states.
- If rsp_ready is already high in RESP, IDLE follows one cycle later. The next command can be accepted 4 cycles after the previous accept (minimum issue interval 4).
- Timeout with TIMEOUT=T: with pready held at 0, abort happens at the T-th ACCESS edge. psel is therefore high for 1+T cycles.
- pready=1 on the same edge the counter would reach T: completion wins, and the normal response is returned with rsp_timeout=0.
- req_valid asserted outside IDLE: held off by req_ready=0. No loss or duplication provided the requester holds req_valid.

## Test plan
- Zero-wait write:
  - Stimulus: addr=0x10, wdata=0xDEADBEEF, pready tied 1.
  - Required: psel high 2 cycles, penable high 1 cycle, pwdata=0xDEADBEEF.
  - Required response: rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states:
  - Stimulus: addr=0x24, pready low 3 ACCESS cycles, then prdata=0x12345678 with pready=1.
  - Required: rsp_rdata=0x12345678, latency 6 cycles.
- Slave error:
  - Stimulus: write to 0x40, pslverr=1 with pready=1.
  - Required: rsp_err=1, rsp_timeout=0.
  - Required: pslverr=1 while pready=0 has no effect.
- Timeout:
  - Stimulus: TIMEOUT=4, pready held 0.
  - Required: abort after 4 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0; psel drops.
  - Required: with TIMEOUT=0 and pready held 0, no abort after 100 cycles.
- Backpressure and back-to-back:
  - Stimulus: two commands queued, rsp_ready low 5 cycles.
  - Required: rsp fields stable and req_ready=0 throughout.
  - Required: second command accepted the cycle after the response handshake returns the FSM to IDLE.
- Reset in ACCESS:
  - Stimulus: assert rst mid-wait.
  - Required: psel/penable/rsp_valid go 0 immediately with no response issued.
  - Required: req_ready=1 one cycle after rst release.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Command/response stream and APB bus signals for apb_master_bridge.
// The master modport is the bridge's view; slave is the requester/APB-slave side.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to APB master, one transfer in flight, with a
// wait-state timeout that aborts a transfer if the slave never raises pready.
module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic                 clk,
    input logic                 rst,
    apb_master_bridge_if.master bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    // Abort fires on the edge where the count would step from T-1 to T.
    localparam logic [CW-1:0] WAIT_LAST = CW'(LAST_I);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [1:0]        state;
    logic [CW-1:0]     wcnt;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;
    logic [DATA_W-1:0] rd_sel;
    logic              wait_expired;

    assign rd_sel       = pwrite_q ? '0 : bus.prdata;
    assign wait_expired = (TIMEOUT > 0) && (wcnt == WAIT_LAST);

    assign bus.req_ready   = (state == IDLE) && !rst;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wcnt          <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        pwrite_q  <= bus.req_write;
                        paddr_q   <= bus.req_addr;
                        pwdata_q  <= bus.req_wdata;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    wcnt      <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    // pready takes priority so a late completion beats the abort.
                    if (bus.pready) begin
                        rsp_rdata_q   <= rd_sel;
                        rsp_err_q     <= bus.pslverr;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state         <= RESP;
                    end else if (wait_expired) begin
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state         <= RESP;
                    end else begin
                        wcnt <= sat_inc(wcnt);
                    end
                end
                default: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
